// File: rtl/cacheline_pkg.sv
// cacheline_pkg
//   Shared types and constants for the cache-line to memory-burst adaptor:
//   the controller state encoding, line/beat/address widths and the mask
//   that aligns a byte address down to the start of its cache line.
package cacheline_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int ADDR_W      = 32;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  // Index of the final beat in a burst; reaching it ends the burst.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Clears the byte-offset-within-line bits of an address.
  localparam logic [ADDR_W-1:0] LINE_ADDR_MASK =
    {{(ADDR_W - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Responder on the cache line-request interface. A 256-bit line fill or
//   write-back is turned into a four-beat 64-bit burst toward memory, and a
//   single-cycle resp_o is returned to the cache once the burst completes.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   line_i      : write-back line from the cache
//   line_o      : fill line to the cache (registered, updated per read beat)
//   address_i   : line address from the cache
//   read_i      : fill request, held until resp_o
//   write_i     : write-back request, held until resp_o (wins over read_i)
//   resp_o      : one-cycle completion pulse to the cache
//   burst_i     : read beat data from memory
//   burst_o     : write beat data to memory
//   address_o   : line-aligned burst address (low 5 bits zero)
//   read_o      : memory burst read request
//   write_o     : memory burst write request
//   resp_i      : memory beat acknowledge, one beat per asserted cycle
//
// Every output comes from a register or is decoded from registered state,
// so no input reaches an output combinationally.
module cacheline_adaptor
  import cacheline_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wr_line;
  logic [LINE_W-1:0]   r_rd_line;
  logic                w_read;
  logic                w_write;
  logic                w_resp;
  logic [BEAT_W-1:0]   w_burst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_write     = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (write_i) begin
          w_state_nxt = ST_WR_BURST;
        end else if (read_i) begin
          w_state_nxt = ST_RD_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        w_read = 1'b1;
        if (resp_i && (r_cnt == LAST_BEAT)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        w_write = 1'b1;
        if (resp_i && (r_cnt == LAST_BEAT)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WR_BURST;
        end
      end
      ST_DONE: begin
        w_resp      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write beat selection from the latched line; zero outside a write burst.
  always_comb begin
    w_burst = {BEAT_W{1'b0}};
    if (r_state == ST_WR_BURST) begin
      case (r_cnt)
        2'd0:    w_burst = r_wr_line[0*BEAT_W +: BEAT_W];
        2'd1:    w_burst = r_wr_line[1*BEAT_W +: BEAT_W];
        2'd2:    w_burst = r_wr_line[2*BEAT_W +: BEAT_W];
        2'd3:    w_burst = r_wr_line[3*BEAT_W +: BEAT_W];
        default: w_burst = {BEAT_W{1'b0}};
      endcase
    end else begin
      w_burst = {BEAT_W{1'b0}};
    end
  end

  // Request latching, beat counter and fill-line slot writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_wr_line <= {LINE_W{1'b0}};
      r_rd_line <= {LINE_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Counter restarts for whichever burst begins next.
          r_cnt <= {CNT_W{1'b0}};
          if (write_i) begin
            r_wr_line <= line_i;
            r_addr    <= address_i & LINE_ADDR_MASK;
          end else if (read_i) begin
            r_addr    <= address_i & LINE_ADDR_MASK;
          end
        end
        ST_RD_BURST: begin
          if (resp_i) begin
            case (r_cnt)
              2'd0:    r_rd_line[0*BEAT_W +: BEAT_W] <= burst_i;
              2'd1:    r_rd_line[1*BEAT_W +: BEAT_W] <= burst_i;
              2'd2:    r_rd_line[2*BEAT_W +: BEAT_W] <= burst_i;
              2'd3:    r_rd_line[3*BEAT_W +: BEAT_W] <= burst_i;
              default: r_rd_line <= r_rd_line;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_WR_BURST: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign read_o    = w_read;
  assign write_o   = w_write;
  assign resp_o    = w_resp;
  assign burst_o   = w_burst;
  assign address_o = r_addr;
  assign line_o    = r_rd_line;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Randomised and directed stimulus for cacheline_adaptor. A transaction-level
//   reference model (mode + beats-taken count + beat arrays) predicts every
//   output each cycle; directed scenarios also pin literal values.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 fill in progress, 2 write-back in progress, 3 completion
  int          m_mode;
  int          m_beats;
  logic [63:0] m_rd [4];
  logic [63:0] m_wr [4];
  logic [31:0] m_addr;
  logic [255:0] exp_line;

  assign exp_line = {m_rd[3], m_rd[2], m_rd[1], m_rd[0]};

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = 0;
      m_beats = 0;
      m_addr  = 32'h0;
      for (int i = 0; i < 4; i++) begin
        m_rd[i] = 64'h0;
        m_wr[i] = 64'h0;
      end
    end else begin
      case (m_mode)
        0: begin
          if (write_i || read_i) begin
            m_addr  = {address_i[31:5], 5'b00000};
            m_beats = 0;
            m_mode  = write_i ? 2 : 1;
            if (write_i) begin
              for (int i = 0; i < 4; i++) m_wr[i] = line_i[i*64 +: 64];
            end
          end
        end
        1: begin
          if (resp_i) begin
            m_rd[m_beats] = burst_i;
            m_beats++;
            if (m_beats == 4) m_mode = 3;
          end
        end
        2: begin
          if (resp_i) begin
            m_beats++;
            if (m_beats == 4) m_mode = 3;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("read_o",  {255'h0, read_o},  {255'h0, (m_mode == 1)});
      chk("write_o", {255'h0, write_o}, {255'h0, (m_mode == 2)});
      chk("resp_o",  {255'h0, resp_o},  {255'h0, (m_mode == 3)});
      chk("line_o",  line_o, exp_line);
      if (m_mode != 0) chk("address_o", {224'h0, address_o}, {224'h0, m_addr});
      if (m_mode == 2) chk("burst_o", {192'h0, burst_o}, {192'h0, m_wr[m_beats]});
    end
  end

  // ---------------- stimulus ----------------
  // Issues one request and services it. Acks follow pat (bit per cycle) when
  // use_pat is set, else are random with the given percentage of gaps. Read
  // beats are taken from l in order, so a completed fill must equal l.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [255:0] l, input bit use_pat,
                        input logic [15:0] pat, input int gap_pct,
                        output int lat, output int n_rd, output int n_wr,
                        output int n_resp, output int k,
                        output logic [255:0] wbeats, output logic [31:0] addr1);
    bit seen;
    bit ack;
    lat = 0; n_rd = 0; n_wr = 0; n_resp = 0; k = 0;
    wbeats = 256'h0; addr1 = 32'h0; seen = 1'b0;
    @(negedge clk);
    address_i = a; line_i = l; read_i = rd; write_i = wr; resp_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) addr1 = address_o;
      if (read_o)  n_rd++;
      if (write_o) n_wr++;
      if (resp_o) begin
        n_resp++;
        seen = 1'b1;
        break;
      end
      ack = use_pat ? pat[(lat - 1) % 16] : ($urandom_range(99) >= gap_pct);
      burst_i = (k < 4) ? l[k*64 +: 64] : {$urandom, $urandom};
      if (ack && write_o && k < 4) wbeats[k*64 +: 64] = burst_o;
      if (ack && (read_o || write_o)) k++;
      resp_i = ack;
    end
    if (!seen) chk("txn_timeout", 256'h0, 256'h1);
    resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    if (resp_o) n_resp++;
  endtask

  localparam logic [255:0] RL = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] WL = 256'hDEADBEEF0123456789ABCDEFFEDCBA987654321000F0F0F0CAFEF00D5555BEEF;

  initial begin
    int lat, n_rd, n_wr, n_resp, k;
    logic [255:0] wb, rl, saved;
    logic [31:0]  a1, ra;
    bit rwr, rrd;

    rst = 1'b1; line_i = 256'h0; address_i = 32'h0; read_i = 1'b0;
    write_i = 1'b0; burst_i = 64'h0; resp_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_o",  {255'h0, resp_o},  256'h0);
    chk("rst_read_o",  {255'h0, read_o},  256'h0);
    chk("rst_write_o", {255'h0, write_o}, 256'h0);
    chk("rst_addr",    {224'h0, address_o}, 256'h0);
    chk("rst_burst",   {192'h0, burst_o}, 256'h0);
    chk("rst_line",    line_o, 256'h0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Fill with back-to-back beats.
    do_txn(1'b0, 1'b1, 32'h1234567F, RL, 1'b1, 16'hFFFF, 0, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("rd_addr",    {224'h0, a1}, {224'h0, 32'h12345660});
    chk("rd_latency", lat, 5);
    chk("rd_beats",   n_rd, 4);
    chk("rd_resp_n",  n_resp, 1);
    chk("rd_line",    line_o, RL);
    chk("model_line", exp_line, RL);

    // Write-back with gaps 1,0,0,1,1,0,1.
    do_txn(1'b1, 1'b0, 32'hA5A5_0013, WL, 1'b1, 16'h0059, 0, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("wr_cycles",  n_wr, 7);
    chk("wr_latency", lat, 8);
    chk("wr_resp_n",  n_resp, 1);
    chk("wr_beats",   wb, WL);
    chk("wr_addr",    {224'h0, a1}, {224'h0, 32'hA5A50000});
    chk("wr_keep_line", line_o, RL);

    // Both requests high: write wins.
    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(1'b1, 1'b1, $urandom, rl, 1'b0, 16'h0, 30, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("both_no_read", n_rd, 0);
    chk("both_wbeats",  wb, rl);
    chk("both_resp_n",  n_resp, 1);

    // Reset after two fill beats.
    @(negedge clk);
    address_i = 32'h0000_1040; read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0001;
    @(negedge clk);
    burst_i = 64'hAAAA_0000_0000_0002;
    @(negedge clk);
    resp_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; read_i = 1'b0;
    chk("mid_rst_read_o", {255'h0, read_o}, 256'h0);
    chk("mid_rst_line",   line_o, 256'h0);
    chk("mid_rst_addr",   {224'h0, address_o}, 256'h0);
    chk("mid_rst_resp",   {255'h0, resp_o}, 256'h0);
    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(1'b0, 1'b1, 32'h0000_1040, rl, 1'b0, 16'h0, 40, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("post_rst_line", line_o, rl);
    chk("post_rst_resp", n_resp, 1);

    // Stray acks in idle, then a fill, then a write-back.
    @(negedge clk); resp_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); resp_i = 1'b0;
    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(1'b0, 1'b1, 32'h7777_7777, rl, 1'b0, 16'h0, 20, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("stray_beats", k, 4);
    chk("stray_line",  line_o, rl);
    chk("stray_resp",  n_resp, 1);
    saved = line_o;
    do_txn(1'b1, 1'b0, 32'h0BAD_F00D, ~rl, 1'b0, 16'h0, 20, lat, n_rd, n_wr, n_resp, k, wb, a1);
    chk("wr_after_line", line_o, saved);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      rwr = $urandom_range(1);
      rrd = rwr ? $urandom_range(1) : 1'b1;
      ra  = $urandom;
      rl  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn(rwr, rrd, ra, rl, 1'b0, 16'h0, $urandom_range(70), lat, n_rd, n_wr, n_resp, k, wb, a1);
      chk("rand_resp_n", n_resp, 1);
      chk("rand_addr", {224'h0, a1}, {224'h0, ra & 32'hFFFF_FFE0});
      if (rwr) chk("rand_wbeats", wb, rl);
      else     chk("rand_line", line_o, rl);
      if (($urandom_range(3)) == 0) begin
        @(negedge clk); resp_i = 1'b1;
        @(negedge clk); resp_i = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
